// File: rtl/spi_pkg.sv
// Shared helpers for the SPI slave: frame-counter sizing.
package spi_pkg;

    // Bit counter must hold 0..size-1 with headroom for the wrap compare.
    function automatic int cnt_width(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer plus a delay flop for edge detection of an async pin.
module spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Next-state: shift the pin through the synchronizer chain.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Synchronizer chain, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;
    assign fall  = ~s2_q & prev_q;

endmodule

// File: rtl/spi.sv
// Mode-0 SPI slave, oversampled by clk: shifts sdi into pdo, pdi out on sdo.
module spi
    import spi_pkg::*;
#(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sck,
    input  logic            sdi,
    output logic            sdo,
    input  logic            scs,
    input  logic [size-1:0] pdi,
    output logic [size-1:0] pdo
);

    localparam int CW = cnt_width(size);

    logic sck_lvl, sck_rise, sck_fall;
    logic scs_lvl, scs_rise, scs_fall;
    logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;
    logic unused_sig;

    spi_sync u_sck (.clk(clk), .rst(rst), .din(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_sync u_scs (.clk(clk), .rst(rst), .din(scs), .level(scs_lvl), .rise(scs_rise), .fall(scs_fall));
    spi_sync u_sdi (.clk(clk), .rst(rst), .din(sdi), .level(sdi_lvl), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

    // Only the synchronized sck edges matter, not its level.
    assign unused_sig = ^{sck_lvl, sdi_rise_unused, sdi_fall_unused};

    logic [size-1:0] tx_q, tx_d;
    logic [size-1:0] rx_q, rx_d;
    logic [size-1:0] pdo_q, pdo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [size-1:0] rx_next;

    assign rx_next = {rx_q[size-2:0], sdi_lvl};

    // Frame control: a new frame load beats any sck edge in the same cycle,
    // and edges outside an active select (including the deselect cycle) are dropped.
    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        pdo_d = pdo_q;
        cnt_d = cnt_q;
        if (scs_rise) begin
            tx_d  = pdi;
            rx_d  = '0;
            cnt_d = '0;
        end else if (scs_lvl && !scs_fall) begin
            if (sck_rise) begin
                rx_d = rx_next;
                if (cnt_q == CW'(size - 1)) begin
                    pdo_d = rx_next;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (sck_fall) begin
                tx_d = {tx_q[size-2:0], 1'b0};
            end
        end
    end

    // Frame state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            pdo_q <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            pdo_q <= pdo_d;
            cnt_q <= cnt_d;
        end
    end

    assign pdo = pdo_q;
    assign sdo = scs_lvl & tx_q[size-1];

endmodule

// File: tb/tb_spi.sv
// Directed bench for the SPI slave: 8-bit and 16-bit instances share the bus pins.
`timescale 1ns/1ps
module tb_spi;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck, sdi, scs;
    logic        sdo8, sdo16;
    logic [7:0]  pdi8, pdo8;
    logic [15:0] pdi16, pdo16;

    int errs   = 0;
    int checks = 0;

    logic [15:0] so8, so16, cap8, cap16;

    always #1000 clk = ~clk;

    spi #(.size(8)) dut8 (
        .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .sdo(sdo8),
        .scs(scs), .pdi(pdi8), .pdo(pdo8)
    );

    spi #(.size(16)) dut16 (
        .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .sdo(sdo16),
        .scs(scs), .pdi(pdi16), .pdo(pdo16)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Drive one frame of n bits, MSB first; record sdo at each sck rise and
    // pdo 5us (between 2 and 3 clk edges' worth of margin) after the last rise.
    task automatic frame(input int n, input logic [15:0] w, input bit keep,
                         output logic [15:0] s8, output logic [15:0] s16,
                         output logic [15:0] p8, output logic [15:0] p16);
        s8 = '0; s16 = '0; p8 = '0; p16 = '0;
        scs = 1'b1;
        #1000 sdi = w[n-1];
        #9000;
        for (int i = 0; i < n; i++) begin
            s8[n-1-i]  = sdo8;
            s16[n-1-i] = sdo16;
            sck = 1'b1;
            #5000;
            if (i == n - 1) begin
                p8  = {8'h00, pdo8};
                p16 = pdo16;
            end
            #5000 sck = 1'b0;
            #1000;
            if (i < n - 1) sdi = w[n-2-i];
            #9000;
        end
        if (!keep) begin
            scs = 1'b0;
            #10000;
        end
    endtask

    initial begin
        rst = 1'b0; sck = 1'b0; sdi = 1'b0; scs = 1'b0;
        pdi8 = 8'h81; pdi16 = 16'h8001;

        // Reset
        #10500;
        chk("reset_pdo8",  {8'h00, pdo8}, 16'h0000);
        chk("reset_sdo8",  {15'h0, sdo8}, 16'h0000);
        chk("reset_pdo16", pdo16,         16'h0000);
        chk("reset_sdo16", {15'h0, sdo16}, 16'h0000);
        rst = 1'b1;
        #10000;

        // First frame
        frame(8, 16'h00A5, 1'b0, so8, so16, cap8, cap16);
        chk("f1_sdo8", so8, 16'h0081);
        chk("f1_pdo8", cap8, 16'h00A5);

        // Back-to-back frame
        #10000;
        frame(8, 16'h005A, 1'b0, so8, so16, cap8, cap16);
        chk("f2_sdo8", so8, 16'h0081);
        chk("f2_pdo8", cap8, 16'h005A);

        // Partial frame leaves pdo alone
        frame(4, 16'h000F, 1'b0, so8, so16, cap8, cap16);
        #10000;
        chk("partial_pdo8", {8'h00, pdo8}, 16'h005A);
        frame(8, 16'h003C, 1'b0, so8, so16, cap8, cap16);
        chk("f3_pdo8", cap8, 16'h003C);

        // Reset mid-frame, pdi changed mid-frame has no effect on this frame
        frame(3, 16'h0006, 1'b1, so8, so16, cap8, cap16);
        pdi8 = 8'hFF;
        rst = 1'b0;
        #6000;
        chk("midrst_pdo8", {8'h00, pdo8}, 16'h0000);
        chk("midrst_sdo8", {15'h0, sdo8}, 16'h0000);
        rst = 1'b1; scs = 1'b0; pdi8 = 8'h81;
        #10000;
        frame(8, 16'h00C3, 1'b0, so8, so16, cap8, cap16);
        chk("f4_pdo8", cap8, 16'h00C3);
        chk("f4_sdo8", so8, 16'h0081);

        // 16-bit frame: full word on the wide instance, wrap on the narrow one
        frame(16, 16'hBEEF, 1'b0, so8, so16, cap8, cap16);
        chk("w16_pdo16", cap16, 16'hBEEF);
        chk("w16_sdo16", so16, 16'h8001);
        chk("w16_pdo8_wrap", cap8, 16'h00EF);
        chk("w16_sdo8_wrap", so8, 16'h8100);
        chk("w16_pdo16_hold", pdo16, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
